// File: rtl/uart_cmd_parser.sv
// Frame parser for SYNC/ADDR/DATA/CHK byte streams from a UART receiver.
// Valid frames write a 4x8 register file; bad or timed-out frames bump a saturating error count.
module uart_cmd_parser #(
    parameter int          TIMEOUT_CLKS = 50000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    output logic [3:0]  o_leds,
    output logic        o_auto_mode,
    output logic [7:0]  o_reg1,
    output logic        o_wr_strobe,
    output logic [1:0]  o_wr_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_err_pulse,
    output logic [7:0]  o_err_cnt
);

    localparam int CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        GET_CHK
    } state_t;

    state_t            r_state;
    logic [7:0]        r_addr;
    logic [7:0]        r_data;
    logic [CNT_W-1:0]  r_to_cnt;

    logic [7:0]        w_chk_exp;
    logic              w_frame_ok;
    logic              w_timeout;

    assign w_chk_exp  = SYNC_BYTE ^ r_addr ^ r_data;
    assign w_frame_ok = (i_rx_byte == w_chk_exp) && (r_addr[7:2] == 6'd0);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_timeout  = (r_state != IDLE) && !i_rx_dv && (r_to_cnt == TO_LAST);

    // reg0[6:4], reg2 and reg3 have no readers; their written value is visible only on o_wr_data.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= 8'd0;
            r_data      <= 8'd0;
            r_to_cnt    <= '0;
            o_leds      <= 4'd0;
            o_auto_mode <= 1'b0;
            o_reg1      <= 8'd0;
            o_wr_strobe <= 1'b0;
            o_wr_addr   <= 2'd0;
            o_wr_data   <= 8'd0;
            o_err_pulse <= 1'b0;
            o_err_cnt   <= 8'd0;
        end else begin
            o_wr_strobe <= 1'b0;
            o_err_pulse <= 1'b0;

            if (i_rx_dv || r_state == IDLE || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_timeout) begin
                r_state     <= IDLE;
                o_err_pulse <= 1'b1;
                if (o_err_cnt != 8'hFF) begin
                    o_err_cnt <= o_err_cnt + 8'd1;
                end
            end else if (i_rx_dv) begin
                case (r_state)
                    IDLE: begin
                        if (i_rx_byte == SYNC_BYTE) begin
                            r_state <= GET_ADDR;
                        end
                    end
                    GET_ADDR: begin
                        r_addr  <= i_rx_byte;
                        r_state <= GET_DATA;
                    end
                    GET_DATA: begin
                        r_data  <= i_rx_byte;
                        r_state <= GET_CHK;
                    end
                    GET_CHK: begin
                        r_state <= IDLE;
                        if (w_frame_ok) begin
                            o_wr_strobe <= 1'b1;
                            o_wr_addr   <= r_addr[1:0];
                            o_wr_data   <= r_data;
                            case (r_addr[1:0])
                                2'd0: begin
                                    o_leds      <= r_data[3:0];
                                    o_auto_mode <= r_data[7];
                                end
                                2'd1:    o_reg1 <= r_data;
                                default: ;
                            endcase
                        end else begin
                            o_err_pulse <= 1'b1;
                            if (o_err_cnt != 8'hFF) begin
                                o_err_cnt <= o_err_cnt + 8'd1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 50000, inter-byte timeout in clk_50M cycles (1 ms at 50 MHz).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 SHALL have port clk_50M  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_rx_dv  input  1  one-cycle strobe: i_rx_byte valid (driven by UART receiver).
REQ-006 SHALL have port i_rx_byte  input  8  received byte, sampled only when i_rx_dv=1.
REQ-007 SHALL have port o_leds  output  4  reg0[3:0].
REQ-008 SHALL have port o_auto_mode  output  1  reg0[7]; 1 selects free-running LED pattern downstream.
REQ-009 SHALL have port o_reg1  output  8  register 1 contents.
REQ-010 SHALL have port o_wr_strobe  output  1  one-cycle pulse per committed write.
REQ-011 SHALL have port o_wr_addr  output  2  address of last committed write.
REQ-012 SHALL have port o_wr_data  output  8  data of last committed write.
REQ-013 SHALL have port o_err_pulse  output  1  one-cycle pulse per rejected frame (checksum, address, or timeout).
REQ-014 SHALL have port o_err_cnt  output  8  saturating count of rejected frames.

Function
REQ-015 Frame = 4 bytes: SYNC_BYTE, ADDR, DATA, CHK; CHK = SYNC_BYTE ^ ADDR ^ DATA (8-bit XOR).
REQ-016 FSM states SHALL be IDLE, GET_ADDR, GET_DATA, GET_CHK; reset state IDLE.
REQ-017 IDLE: byte == SYNC_BYTE -> GET_ADDR; any other byte discarded, no error.
REQ-018 GET_ADDR: any byte captured as ADDR -> GET_DATA; GET_DATA: byte captured as DATA -> GET_CHK.
REQ-019 GET_CHK: byte received -> IDLE; commit if CHK matches and ADDR[7:2]==0, else reject.
REQ-020 Commit: reg[ADDR[1:0]] <= DATA, o_wr_addr/o_wr_data updated, o_wr_strobe=1 in the cycle after the CHK byte's i_rx_dv cycle (latency 1).
REQ-021 Register file: 4 x 8 bit; reg2, reg3 writable but not exported except via o_wr_* outputs.
REQ-022 Outputs o_leds, o_auto_mode, o_reg1 SHALL be registered, changing in the same cycle as o_wr_strobe.
REQ-023 Reject: no register change, o_err_pulse=1 in the cycle after the CHK byte, o_err_cnt += 1 saturating at 255.
REQ-024 Timeout counter: cleared on every i_rx_dv and in IDLE; counts while in GET_ADDR/GET_DATA/GET_CHK.
REQ-025 Counter reaching TIMEOUT_CLKS-1 with no i_rx_dv SHALL return FSM to IDLE and count as a reject (o_err_pulse, o_err_cnt).
REQ-026 i_rx_dv in the same cycle as timeout expiry: byte wins, processed normally, no timeout.
REQ-027 SYNC_BYTE received in GET_ADDR/GET_DATA/GET_CHK SHALL be treated as payload data (no resync).
REQ-028 o_wr_strobe and o_err_pulse SHALL never be high in the same cycle.
REQ-029 Back-to-back frames with consecutive i_rx_dv cycles SHALL be accepted with no dropped bytes.

Reset
REQ-030 rst_n=0 SHALL immediately force: FSM IDLE, timeout counter 0, all registers 0, o_leds=0, o_auto_mode=0, o_reg1=0, o_wr_strobe=0, o_wr_addr=0, o_wr_data=0, o_err_pulse=0, o_err_cnt=0.
REQ-031 Reset mid-frame SHALL abandon the frame without counting an error; first byte after release parsed from IDLE.

Verification
REQ-032 Bytes A5,00,8F,2A -> one o_wr_strobe, o_leds=4'hF, o_auto_mode=1, o_err_cnt=0.
REQ-033 Bytes A5,01,3C,98 -> o_reg1=8'h3C, o_wr_addr=1; then A5,01,3C,99 -> o_err_pulse once, o_reg1 unchanged, o_err_cnt=1.
REQ-034 Bytes 12,A5,04,00,A1 -> leading 12 ignored, address reject, o_err_cnt=1, no register change.
REQ-035 A5,00 then idle TIMEOUT_CLKS cycles -> o_err_pulse once, FSM IDLE; following A5,00,05,A0 commits o_leds=4'h5.
REQ-036 300 bad-checksum frames -> o_err_cnt saturates at 255; rst_n pulse mid-frame -> all outputs 0, next valid frame commits.
